// File: rtl/forward_hazard_unit.sv
// Forwarding and hazard control for a classic 5-stage in-order pipeline.
// Tracks the instructions in EX, MEM and WB, selects EX operand bypasses,
// detects load-use hazards and data-memory wait states, and counts IF/ID
// stall cycles. Control outputs are combinational from the tracked state and
// the current-cycle ID/memory inputs so the pipeline can react in the same
// cycle; the operand selects depend on tracked state only.
module forward_hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2,
    parameter int CNT_W      = 16
) (
    input  logic                            clk,
    input  logic                            arst_n,
    input  logic                            id_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0]   id_rs,
    input  logic [REG_ADDR_W-1:0]           id_rd,
    input  logic                            id_reg_write,
    input  logic                            id_mem_read,
    input  logic                            flush,
    input  logic                            mem_ready,
    output logic [2*NUM_SRC-1:0]            fwd_sel,
    output logic                            stall_if_id,
    output logic                            bubble_id_ex,
    output logic                            freeze_pipe,
    output logic [CNT_W-1:0]                stall_cnt
);

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = {REG_ADDR_W{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]      CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    // Pipeline records: source addresses are only needed while in EX.
    logic                          ex_valid_r;
    logic [REG_ADDR_W-1:0]         ex_rd_r;
    logic                          ex_reg_write_r;
    logic                          ex_mem_read_r;
    logic [NUM_SRC*REG_ADDR_W-1:0] ex_rs_r;

    logic                          mem_valid_r;
    logic [REG_ADDR_W-1:0]         mem_rd_r;
    logic                          mem_reg_write_r;
    logic                          mem_mem_read_r;

    logic                          wb_valid_r;
    logic [REG_ADDR_W-1:0]         wb_rd_r;
    logic                          wb_reg_write_r;

    state_t                        state_r;
    logic                          flush_pending_r;
    logic [CNT_W-1:0]              stall_cnt_r;

    logic                          mem_load_s;
    logic                          mem_wait_s;
    logic                          flush_eff_s;
    logic                          load_use_s;
    logic                          stall_s;
    logic                          bubble_s;
    logic [2*NUM_SRC-1:0]          fwd_sel_s;

    // A record produces register a when it is live, writes, and a is not x0.
    function automatic logic hit(
        input logic                  v,
        input logic                  we,
        input logic [REG_ADDR_W-1:0] rd,
        input logic [REG_ADDR_W-1:0] a
    );
        hit = v & we & (rd != ZERO_ADDR) & (rd == a);
    endfunction

    // Hazard detection: memory wait dominates, then flush, then load-use.
    always_comb begin
        // While in MEM_WAIT the record in MEM is a frozen load by construction.
        mem_load_s  = (state_r == ST_MEM_WAIT) | (mem_valid_r & mem_mem_read_r);
        mem_wait_s  = mem_load_s & ~mem_ready;
        flush_eff_s = flush | flush_pending_r;
        load_use_s  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_valid & ex_mem_read_r &
                hit(ex_valid_r, ex_reg_write_r, ex_rd_r, id_rs[i*REG_ADDR_W +: REG_ADDR_W])) begin
                load_use_s = 1'b1;
            end else begin
                load_use_s = load_use_s;
            end
        end
        stall_s  = mem_wait_s | (load_use_s & ~flush_eff_s);
        bubble_s = load_use_s & ~mem_wait_s & ~flush_eff_s;
    end

    // Operand bypass selection; the younger producer in MEM wins over WB,
    // except a load in MEM whose data is not yet available.
    always_comb begin
        fwd_sel_s = {(2*NUM_SRC){1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!ex_valid_r) begin
                fwd_sel_s[2*i +: 2] = 2'b00;
            end else if (hit(mem_valid_r, mem_reg_write_r, mem_rd_r,
                             ex_rs_r[i*REG_ADDR_W +: REG_ADDR_W]) & ~mem_mem_read_r) begin
                fwd_sel_s[2*i +: 2] = 2'b10;
            end else if (hit(wb_valid_r, wb_reg_write_r, wb_rd_r,
                             ex_rs_r[i*REG_ADDR_W +: REG_ADDR_W])) begin
                fwd_sel_s[2*i +: 2] = 2'b01;
            end else begin
                fwd_sel_s[2*i +: 2] = 2'b00;
            end
        end
    end

    // Record pipeline: shift on advance, hold everything while frozen.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ex_valid_r      <= 1'b0;
            ex_rd_r         <= ZERO_ADDR;
            ex_reg_write_r  <= 1'b0;
            ex_mem_read_r   <= 1'b0;
            ex_rs_r         <= {(NUM_SRC*REG_ADDR_W){1'b0}};
            mem_valid_r     <= 1'b0;
            mem_rd_r        <= ZERO_ADDR;
            mem_reg_write_r <= 1'b0;
            mem_mem_read_r  <= 1'b0;
            wb_valid_r      <= 1'b0;
            wb_rd_r         <= ZERO_ADDR;
            wb_reg_write_r  <= 1'b0;
        end else if (!mem_wait_s) begin
            wb_valid_r      <= mem_valid_r;
            wb_rd_r         <= mem_rd_r;
            wb_reg_write_r  <= mem_reg_write_r;
            mem_valid_r     <= ex_valid_r;
            mem_rd_r        <= ex_rd_r;
            mem_reg_write_r <= ex_reg_write_r;
            mem_mem_read_r  <= ex_mem_read_r;
            // Fields are captured unconditionally; only valid gates their use.
            ex_valid_r      <= id_valid & ~bubble_s & ~flush_eff_s;
            ex_rd_r         <= id_rd;
            ex_reg_write_r  <= id_reg_write;
            ex_mem_read_r   <= id_mem_read;
            ex_rs_r         <= id_rs;
        end
    end

    // Run / memory-wait state machine and remembered flush across a freeze.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_r         <= ST_RUN;
            flush_pending_r <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (mem_wait_s) begin
                        state_r <= ST_MEM_WAIT;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_ready) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_MEM_WAIT;
                    end
                end
                default: state_r <= ST_RUN;
            endcase
            if (mem_wait_s) begin
                flush_pending_r <= flush_pending_r | flush;
            end else begin
                flush_pending_r <= 1'b0;
            end
        end
    end

    // Saturating count of IF/ID stall cycles.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_s && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end
    end

    assign fwd_sel      = fwd_sel_s;
    assign stall_if_id  = stall_s;
    assign bubble_id_ex = bubble_s;
    assign freeze_pipe  = mem_wait_s;
    assign stall_cnt    = stall_cnt_r;

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Bench for forward_hazard_unit: a directed cycle table, hand-written
// multi-cycle corner cases, and a randomized run against a stage-array model.
module tb_forward_hazard_unit;

    localparam int W   = 5;
    localparam int NS  = 2;
    localparam int CW  = 16;
    localparam int CWS = 3;

    logic            clk = 1'b0;
    logic            arst_n;
    logic            id_valid;
    logic [NS*W-1:0] id_rs;
    logic [W-1:0]    id_rd;
    logic            id_reg_write;
    logic            id_mem_read;
    logic            flush;
    logic            mem_ready;

    logic [2*NS-1:0] fwd_sel, fwd_sel_b;
    logic            stall_if_id, stall_if_id_b;
    logic            bubble_id_ex, bubble_id_ex_b;
    logic            freeze_pipe, freeze_pipe_b;
    logic [CW-1:0]   stall_cnt;
    logic [CWS-1:0]  stall_cnt_b;

    forward_hazard_unit #(.REG_ADDR_W(W), .NUM_SRC(NS), .CNT_W(CW)) dut (
        .clk(clk), .arst_n(arst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
        .mem_ready(mem_ready), .fwd_sel(fwd_sel), .stall_if_id(stall_if_id),
        .bubble_id_ex(bubble_id_ex), .freeze_pipe(freeze_pipe), .stall_cnt(stall_cnt)
    );

    // Narrow-counter instance so saturation is reachable in a short run.
    forward_hazard_unit #(.REG_ADDR_W(W), .NUM_SRC(NS), .CNT_W(CWS)) dut_b (
        .clk(clk), .arst_n(arst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
        .mem_ready(mem_ready), .fwd_sel(fwd_sel_b), .stall_if_id(stall_if_id_b),
        .bubble_id_ex(bubble_id_ex_b), .freeze_pipe(freeze_pipe_b), .stall_cnt(stall_cnt_b)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%h required=%h", name, act, exp);
    endtask

    function automatic logic [31:0] main_out();
        return {9'd0, fwd_sel, stall_if_id, bubble_id_ex, freeze_pipe, stall_cnt};
    endfunction

    function automatic logic [31:0] small_out();
        return {22'd0, fwd_sel_b, stall_if_id_b, bubble_id_ex_b, freeze_pipe_b, stall_cnt_b};
    endfunction

    task automatic drive(input logic v, input int r1, input int r2, input int rd,
                         input logic rw, input logic mr, input logic fl, input logic rdy);
        id_valid     = v;
        id_rs        = {W'(r2), W'(r1)};
        id_rd        = W'(rd);
        id_reg_write = rw;
        id_mem_read  = mr;
        flush        = fl;
        mem_ready    = rdy;
    endtask

    task automatic step(input logic v, input int r1, input int r2, input int rd,
                        input logic rw, input logic mr, input logic fl, input logic rdy);
        @(negedge clk);
        drive(v, r1, r2, rd, rw, mr, fl, rdy);
        #1;
    endtask

    // Reference model: stage 0 = EX, 1 = MEM, 2 = WB.
    bit p_v[3];
    int p_rd[3];
    bit p_rw[3];
    bit p_mr[3];
    int p_rs[3][NS];
    bit m_fpend;
    int m_cnt;
    int m_cnt_s;

    function automatic bit writes(input int s, input int a);
        return p_v[s] && p_rw[s] && (p_rd[s] != 0) && (p_rd[s] == a);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        arst_n = 1'b0;
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        @(negedge clk);
        arst_n = 1'b1;
        for (int s = 0; s < 3; s++) p_v[s] = 1'b0;
        m_fpend = 1'b0;
        m_cnt   = 0;
        m_cnt_s = 0;
    endtask

    typedef struct {
        logic v; int r1; int r2; int rd; logic rw; logic mr; logic fl; logic rdy;
        logic [3:0] fwd; logic st; logic bb; logic fz; int cnt;
    } vec_t;

    vec_t vec[16];

    initial begin
        // ALU chain, distance-2, double writer, load-use, x0 cases.
        vec[0]  = '{1'b1, 1, 2, 5,  1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 0};
        vec[1]  = '{1'b1, 5, 0, 6,  1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 0};
        vec[2]  = '{1'b1, 1, 2, 7,  1'b1, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 0};
        vec[3]  = '{1'b1, 1, 1, 9,  1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 0};
        vec[4]  = '{1'b1, 3, 7, 10, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 0};
        vec[5]  = '{1'b1, 0, 0, 7,  1'b1, 1'b0, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 0};
        vec[6]  = '{1'b1, 0, 0, 7,  1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 0};
        vec[7]  = '{1'b1, 0, 7, 11, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 0};
        vec[8]  = '{1'b1, 0, 0, 8,  1'b1, 1'b1, 1'b0, 1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 0};
        vec[9]  = '{1'b1, 8, 0, 12, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 0};
        vec[10] = '{1'b1, 8, 0, 12, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1};
        vec[11] = '{1'b1, 1, 1, 0,  1'b1, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 1};
        vec[12] = '{1'b1, 0, 0, 13, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1};
        vec[13] = '{1'b1, 0, 0, 0,  1'b1, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1};
        vec[14] = '{1'b1, 0, 0, 14, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1};
        vec[15] = '{1'b0, 0, 0, 0,  1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1};

        // Reset with active-looking inputs: outputs must still be zero.
        arst_n = 1'b0;
        drive(1'b1, 3, 3, 3, 1'b1, 1'b1, 1'b1, 1'b0);
        #3;
        check("reset_main", main_out(), 32'd0);
        check("reset_small", small_out(), 32'd0);
        do_reset();

        for (int k = 0; k < 16; k++) begin
            step(vec[k].v, vec[k].r1, vec[k].r2, vec[k].rd, vec[k].rw, vec[k].mr,
                 vec[k].fl, vec[k].rdy);
            check($sformatf("vec%0d", k), main_out(),
                  {9'd0, vec[k].fwd, vec[k].st, vec[k].bb, vec[k].fz, 16'(vec[k].cnt)});
        end

        // Memory wait of three cycles with a flush in the second one.
        do_reset();
        step(1'b1, 0, 0, 8, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 2, 3, 1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 3, 3, 2, 1'b1, 1'b0, 1'b0, 1'b0);
        check("mw_c1", main_out(), {9'd0, 4'b0000, 1'b1, 1'b0, 1'b1, 16'd0});
        step(1'b1, 3, 3, 2, 1'b1, 1'b0, 1'b1, 1'b0);
        check("mw_c2", main_out(), {9'd0, 4'b0000, 1'b1, 1'b0, 1'b1, 16'd1});
        step(1'b1, 3, 3, 2, 1'b1, 1'b0, 1'b0, 1'b0);
        check("mw_c3", main_out(), {9'd0, 4'b0000, 1'b1, 1'b0, 1'b1, 16'd2});
        // ID now reads x1 (produced by the add about to enter MEM).
        step(1'b1, 1, 0, 3, 1'b1, 1'b0, 1'b0, 1'b1);
        check("mw_release", main_out(), {9'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 16'd3});
        step(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("mw_bubble", main_out(), {9'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 16'd3});

        // Flush overrides a load-use stall.
        do_reset();
        step(1'b1, 0, 0, 8, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 8, 0, 9, 1'b1, 1'b0, 1'b1, 1'b1);
        check("lu_flush", main_out(), {9'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 16'd0});

        // Asynchronous reset in the middle of a memory wait.
        do_reset();
        step(1'b1, 0, 0, 8, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 2, 3, 1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("pre_rst_wait", main_out(), {9'd0, 4'b0000, 1'b1, 1'b0, 1'b1, 16'd1});
        arst_n = 1'b0;
        #1;
        check("rst_mid_main", main_out(), 32'd0);
        check("rst_mid_small", small_out(), 32'd0);
        @(negedge clk);
        arst_n = 1'b1;
        drive(1'b1, 8, 8, 4, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check("rst_after", main_out(), 32'd0);
        step(1'b1, 8, 8, 4, 1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_run", main_out(), 32'd0);

        // Randomized run against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            bit iv, rw, mr, fl, rdy, mw, fe, lu, st, bb;
            int rr[NS];
            int rd;
            logic [3:0] fwd;
            @(negedge clk);
            iv  = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NS; i++) rr[i] = $urandom_range(0, 3);
            rd  = $urandom_range(0, 3);
            rw  = ($urandom_range(0, 3) != 0);
            mr  = ($urandom_range(0, 2) == 0);
            fl  = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            drive(iv, rr[0], rr[1], rd, rw, mr, fl, rdy);
            #1;
            mw = p_v[1] && p_mr[1] && !rdy;
            fe = fl || m_fpend;
            lu = 1'b0;
            if (iv && p_mr[0]) begin
                for (int i = 0; i < NS; i++) if (writes(0, rr[i])) lu = 1'b1;
            end
            st  = mw || (lu && !fe);
            bb  = lu && !mw && !fe;
            fwd = 4'b0000;
            if (p_v[0]) begin
                for (int i = 0; i < NS; i++) begin
                    if (writes(1, p_rs[0][i]) && !p_mr[1]) fwd[2*i +: 2] = 2'b10;
                    else if (writes(2, p_rs[0][i]))        fwd[2*i +: 2] = 2'b01;
                end
            end
            check($sformatf("rand%0d", c), main_out(),
                  {9'd0, fwd, st, bb, mw, 16'(m_cnt)});
            check($sformatf("rand_sat%0d", c), small_out(),
                  {22'd0, fwd, st, bb, mw, 3'(m_cnt_s)});
            if (st) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt_s < 7)   m_cnt_s++;
            end
            if (!mw) begin
                for (int s = 2; s > 0; s--) begin
                    p_v[s]  = p_v[s-1];
                    p_rd[s] = p_rd[s-1];
                    p_rw[s] = p_rw[s-1];
                    p_mr[s] = p_mr[s-1];
                    for (int i = 0; i < NS; i++) p_rs[s][i] = p_rs[s-1][i];
                end
                p_v[0]  = iv && !bb && !fe;
                p_rd[0] = rd;
                p_rw[0] = rw;
                p_mr[0] = mr;
                for (int i = 0; i < NS; i++) p_rs[0][i] = rr[i];
                m_fpend = 1'b0;
            end else if (fl) begin
                m_fpend = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/forward_hazard_unit.md
FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

Interface
REQ-001 Parameter REG_ADDR_W, default 5, SHALL set the register address width.
REQ-002 Parameter NUM_SRC, default 2, range 1..4, SHALL set the number of source operands per instruction.
REQ-003 Parameter CNT_W, default 16, SHALL set the stall counter width.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 arst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 id_valid  input  1  SHALL mark a valid instruction in ID.
REQ-007 id_rs  input  NUM_SRC*REG_ADDR_W  SHALL carry the ID source addresses; source i occupies bits [i*REG_ADDR_W +: REG_ADDR_W].
REQ-008 id_rd, id_reg_write, id_mem_read  input  REG_ADDR_W/1/1  SHALL carry the ID destination, write-enable and load flag.
REQ-009 flush  input  1  SHALL squash the instruction currently in ID (taken branch/jump).
REQ-010 mem_ready  input  1  SHALL be high when the data memory completes the access in MEM.
REQ-011 fwd_sel  output  2*NUM_SRC  SHALL be the EX operand select per source: 00 regfile, 01 WB data, 10 MEM ALU result; 11 is never driven.
REQ-012 stall_if_id  output  1  SHALL hold PC and IF/ID.
REQ-013 bubble_id_ex  output  1  SHALL load a NOP into ID/EX.
REQ-014 freeze_pipe  output  1  SHALL hold ID/EX, EX/MEM and MEM/WB.
REQ-015 stall_cnt  output  CNT_W  SHALL count stall_if_id cycles.

Function
REQ-016 The unit SHALL keep three registered records ex_rec, mem_rec, wb_rec: {valid, rd, reg_write, mem_read, rs[NUM_SRC]}; rs is kept only in ex_rec.
REQ-017 hit(rec,a) SHALL be rec.valid & rec.reg_write & rec.rd!=0 & rec.rd==a; register 0 never forwards or stalls.
REQ-018 fwd_sel[i] SHALL be combinational from registers: 10 if hit(mem_rec, ex_rec.rs[i]) and not mem_rec.mem_read; else 01 if hit(wb_rec, ex_rec.rs[i]); else 00; MEM has priority over WB.
REQ-019 If ex_rec is invalid, all fwd_sel SHALL be 00.
REQ-020 mem_wait = mem_rec.valid & mem_rec.mem_read & !mem_ready; load_use = id_valid & ex_rec.mem_read & any hit(ex_rec, id_rs[i]).
REQ-021 FSM states RUN and MEM_WAIT: RUN->MEM_WAIT when mem_wait; MEM_WAIT->RUN on the first cycle mem_ready=1 (that cycle advances).
REQ-022 freeze_pipe SHALL equal mem_wait; stall_if_id = mem_wait | (load_use & !flush_eff); bubble_id_ex = load_use & !mem_wait & !flush_eff.
REQ-023 Priority SHALL be mem_wait > flush > load_use.
REQ-024 On freeze: all records hold, no shift.
REQ-025 On advance: wb_rec<=mem_rec; mem_rec<=ex_rec; ex_rec<=ID record if id_valid & !bubble_id_ex & !flush_eff, else ex_rec.valid<=0.
REQ-026 flush asserted during freeze SHALL set flush_pending; flush_eff = flush | flush_pending; flush_pending clears on the first advance cycle.
REQ-027 A load-use stall SHALL last exactly one cycle per hazard; the consumer then forwards from WB (01).
REQ-028 stall_cnt SHALL increment on each cycle with stall_if_id=1 and saturate at all-ones.
REQ-029 Outputs SHALL be glitch-free with respect to registered state; no combinational path from fwd_sel to any input.

Reset
REQ-030 With arst_n low, all record valids, flush_pending and stall_cnt SHALL be 0, the state SHALL be RUN, and all outputs SHALL be 0, immediately and independent of clk.
REQ-031 Reset asserted mid-stall or mid-MEM_WAIT SHALL discard all in-flight records; the first cycle after release is RUN with no stall.

Verification
REQ-032 ALU chain: add x5 then add x6 using rs1=x5 back to back -> fwd_sel[1:0]=10 in the consumer's EX cycle, no stall.
REQ-033 Distance 2: producer x7, one independent instruction, consumer rs2=x7 -> fwd_sel[3:2]=01; with both MEM and WB writing x7 -> 10.
REQ-034 Load-use: lw x8, then rs1=x8 -> stall_if_id=1 and bubble_id_ex=1 for exactly one cycle, then fwd_sel[1:0]=01, stall_cnt=1.
REQ-035 x0: producer rd=0 with reg_write=1, consumer rs1=0 -> fwd_sel=00, no stall.
REQ-036 Memory wait: load in MEM, mem_ready=0 for 3 cycles with flush pulsed in cycle 2 -> freeze_pipe=1 and stall_if_id=1 for 3 cycles; on release ex_rec receives a bubble; stall_cnt=3.
REQ-037 Async reset mid-MEM_WAIT -> all outputs 0 at once; RUN after release.
